matmul_result_reader: RTL and testbench

MATMUL_RESULT_READER -- requirements
Module: matmul_result_reader

---
 rtl/matmul_pkg.sv | 18 +
 rtl/matmul_rd_fifo.sv | 80 ++++++++
 rtl/matmul_result_reader.sv | 175 +++++++++++++++++
 tb/tb_matmul_result_reader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants and the reader state type for the matmul
// result-drain path.
//   DWIDTH     - result word width, matches the matmul BRAM data width
//   AWIDTH     - result BRAM address width (1024-word RAM)
//   rd_state_t - reader control states
package matmul_pkg;

  localparam int DWIDTH = 16;
  localparam int AWIDTH = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_t;

endpackage

// File: rtl/matmul_rd_fifo.sv
// matmul_rd_fifo: small circular FIFO buffering BRAM read data ahead of the
// registered stream stage.
//   i_clk, i_reset  - clock, synchronous active-high reset
//   i_push, i_data  - write strobe and data
//   i_pop           - remove the head entry
//   o_data          - head entry (valid while o_empty = 0)
//   o_count         - current occupancy, used by the reader for credits
//   o_full, o_empty - occupancy flags
module matmul_rd_fifo #(
  parameter int  DWIDTH     = 16,
  parameter int  FIFO_DEPTH = 4,
  localparam int CW         = $clog2(FIFO_DEPTH + 1),
  localparam int PW         = $clog2(FIFO_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_pop,
  output logic [DWIDTH-1:0] o_data,
  output logic [CW-1:0]     o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] v;
    if (p == PW'(FIFO_DEPTH - 1)) begin
      v = '0;
    end else begin
      v = p + PW'(1);
    end
    return v;
  endfunction

  assign o_full    = (r_count == CW'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage write; entries need no reset because the count gates visibility
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together keeps the count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/matmul_result_reader.sv
// matmul_result_reader: drains num_words results from the matmul result BRAM,
// starting at base_addr (wrapping at the top of the RAM), into a
// valid/ready stream with a final-beat marker.
//   clk, reset            - clock, synchronous active-high reset
//   start                 - drain request, only honoured while idle
//   base_addr, num_words  - drain window, captured when start is accepted
//   bram_en, bram_addr    - BRAM read port (1-cycle read latency)
//   bram_rdata            - BRAM read data
//   out_data, out_valid,
//   out_ready, out_last   - result stream
//   busy, done            - activity flag and one-cycle completion pulse
module matmul_result_reader #(
  parameter int DWIDTH     = matmul_pkg::DWIDTH,
  parameter int AWIDTH     = matmul_pkg::AWIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   num_words,
  output logic              bram_en,
  output logic [AWIDTH-1:0] bram_addr,
  input  logic [DWIDTH-1:0] bram_rdata,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  import matmul_pkg::*;

  localparam int           CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [AWIDTH:0] ONE = (AWIDTH + 1)'(1);

  rd_state_t         r_state;
  rd_state_t         w_next_state;
  logic [AWIDTH-1:0] r_base;
  logic [AWIDTH:0]   r_num;
  logic [AWIDTH:0]   r_issued;
  logic [AWIDTH:0]   r_beat;
  logic              r_inflight;
  logic              r_busy;
  logic              r_done;
  logic              r_out_valid;
  logic [DWIDTH-1:0] r_out_data;
  logic              r_out_last;

  logic [DWIDTH-1:0] w_fifo_data;
  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_accept;
  logic              w_credit;
  logic              w_issue;
  logic              w_pop;
  logic              w_xfer;

  matmul_rd_fifo #(
    .DWIDTH     (DWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (r_inflight),
    .i_data  (bram_rdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_accept = (r_state == IDLE) && start;
  // A read is only issued when its data is guaranteed a FIFO slot: the
  // read launched last cycle has not landed yet, so it holds a credit too.
  assign w_credit = (int'(w_fifo_count) + int'(r_inflight)) < FIFO_DEPTH;
  assign w_issue  = (r_state == READ) && w_credit && !w_fifo_full && (r_issued < r_num);
  assign w_xfer   = r_out_valid && out_ready;
  // Refill the output register whenever it is empty or being consumed.
  assign w_pop    = !w_fifo_empty && (!r_out_valid || out_ready);

  assign bram_en   = w_issue;
  assign bram_addr = r_base + r_issued[AWIDTH-1:0];
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

  // Next-state decode for the drain sequence
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            w_next_state = READ;
          end else begin
            w_next_state = FINISH;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      READ: begin
        if (w_issue && ((r_issued + ONE) == r_num)) begin
          w_next_state = DRAIN;
        end else begin
          w_next_state = READ;
        end
      end
      DRAIN: begin
        if (w_xfer && r_out_last) begin
          w_next_state = FINISH;
        end else begin
          w_next_state = DRAIN;
        end
      end
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Control state, captured request, counters and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_beat     <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_busy     <= (w_next_state != IDLE);
      r_done     <= (w_next_state == FINISH);
      r_inflight <= w_issue;
      if (w_accept) begin
        r_base   <= base_addr;
        r_num    <= num_words;
        r_issued <= '0;
        r_beat   <= '0;
      end else begin
        if (w_issue) begin
          r_issued <= r_issued + ONE;
        end
        if (w_pop) begin
          r_beat <= r_beat + ONE;
        end
      end
    end
  end

  // Registered stream stage; holds its contents while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_fifo_data;
      r_out_last  <= (r_beat == (r_num - ONE));
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_result_reader.sv
// Bench for matmul_result_reader: BRAM model, queue-based scoreboard
// derived from the drain window, a vector table and hand-written corner
// sequences (timing, empty drain, ignored restart, mid-drain reset).
module tb_matmul_result_reader;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int FD = 4;

  typedef struct {
    int base;
    int num;
    int mode;
    int exp_beats;
    int exp_last;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_d;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  bit            prev_stall = 1'b0;
  int            ready_mode = 0;
  int            exp_base = 0;
  int            exp_total = 0;
  int            issued_seen = 0;
  int            beats_seen = 0;
  int            last_cnt = 0;
  int            last_data_seen = 0;
  int            done_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  vec_t          vecs [12];

  always #5 clk = ~clk;

  matmul_result_reader #(.DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .bram_en    (bram_en),
    .bram_addr  (bram_addr),
    .bram_rdata (bram_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  // BRAM with one cycle of read latency
  always @(posedge clk) begin
    if (bram_en === 1'b1) bram_rdata <= mem[bram_addr];
  end

  // Sink ready: 0 = always ready, 1 = random 50%, otherwise stalled
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: addresses, credits, stream order, last flag, stalls, done
  always @(negedge clk) begin
    if (bram_en === 1'b1) begin
      check("bram_addr", 32'(bram_addr), 32'((exp_base + issued_seen) % 1024));
      check("read_budget", 32'(issued_seen < exp_total), 32'd1);
      check("credit", 32'((issued_seen - beats_seen) <= FD), 32'd1);
      issued_seen++;
    end
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(prev_data));
      check("hold_last", 32'(out_last), 32'(prev_last));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        check("beat_data", 32'(out_data), 32'(exp_d));
      end
      check("beat_last", 32'(out_last), 32'(beats_seen == exp_total - 1));
      if (out_last === 1'b1) begin
        last_cnt++;
        last_data_seen = int'(out_data);
      end
      beats_seen++;
    end
    prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
    prev_data  = out_data;
    prev_last  = out_last;
    if (done === 1'b1) done_cnt++;
  end

  task automatic start_drain(input int b, input int n);
    @(posedge clk); #1;
    exp_base = b; exp_total = n; issued_seen = 0; beats_seen = 0; last_cnt = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % 1024]);
    start = 1'b1; base_addr = b[AW-1:0]; num_words = n[AW:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    @(negedge clk); #1;
    check("done_single", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bram_en"}, 32'(bram_en), 32'd0);
    check({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d0;
    for (int a = 0; a < 1024; a++) mem[a] = DW'(a + 1);

    // Vector table: drain window, sink behaviour, expected beats and last word
    vecs[0] = '{1020, 8, 0, 0, 0};
    vecs[1] = '{3, 64, 1, 0, 0};
    vecs[2] = '{1000, 64, 1, 0, 0};
    vecs[3] = '{0, 1, 0, 0, 0};
    vecs[4] = '{1023, 3, 1, 0, 0};
    vecs[5] = '{7, 1024, 0, 0, 0};
    vecs[6] = '{512, 5, 1, 0, 0};
    vecs[7] = '{1021, 40, 1, 0, 0};
    for (int i = 8; i < 12; i++) begin
      vecs[i].base = int'($urandom_range(0, 1023));
      vecs[i].num  = int'($urandom_range(1, 48));
      vecs[i].mode = int'($urandom_range(0, 1));
    end
    for (int i = 0; i < 12; i++) begin
      vecs[i].exp_beats = vecs[i].num;
      vecs[i].exp_last  = ((vecs[i].base + vecs[i].num - 1) % 1024) + 1;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("rst");

    // 16-word drain with free-flowing sink: latency, no bubbles, done timing
    ready_mode = 0;
    start_drain(0, 16);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("first_latency", 32'(out_valid), 32'd0);
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("no_bubble", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    check("done_after_last", 32'(done), 32'd1);
    check("busy_in_finish", 32'(busy), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
    check("beats16", 32'(beats_seen), 32'd16);
    check("last16", 32'(last_data_seen), 32'd16);

    // Empty drain: immediate completion, no reads or beats
    start_drain(0, 0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_bram_en", 32'(bram_en), 32'd0);
    check("zero_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("zero_done_off", 32'(done), 32'd0);
    check("zero_idle", 32'(busy), 32'd0);
    check("zero_reads", 32'(issued_seen), 32'd0);

    // Table-driven drains
    for (int i = 0; i < 12; i++) begin
      ready_mode = vecs[i].mode;
      start_drain(vecs[i].base, vecs[i].num);
      wait_done(vecs[i].num * 6 + 100);
      check("vec_beats", 32'(beats_seen), 32'(vecs[i].exp_beats));
      check("vec_last_cnt", 32'(last_cnt), 32'd1);
      check("vec_last_data", 32'(last_data_seen), 32'(vecs[i].exp_last));
      check("vec_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Restart attempt during READ is ignored
    ready_mode = 0;
    start_drain(100, 20);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd500; num_words = 11'd5;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 10'd900; num_words = 11'd2;
    check("restart_busy", 32'(busy), 32'd1);
    wait_done(300);
    check("restart_beats", 32'(beats_seen), 32'd20);
    check("restart_last", 32'(last_data_seen), 32'd120);

    // Long stall: output must hold, FIFO must fill without overflow
    ready_mode = 2;
    start_drain(40, 12);
    repeat (20) @(negedge clk);
    #1;
    check("stall_reads", 32'(issued_seen), 32'(FD + 1));
    ready_mode = 0;
    wait_done(200);
    check("stall_beats", 32'(beats_seen), 32'd12);

    // Mid-drain reset aborts without done, then a fresh drain completes
    ready_mode = 0;
    start_drain(0, 32);
    k = 0;
    while (beats_seen < 5 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check("abort_reached", 32'(beats_seen >= 5), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_total = 0;
    @(negedge clk);
    check_all_zero("abort");
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    start_drain(0, 16);
    wait_done(200);
    check("after_abort_beats", 32'(beats_seen), 32'd16);
    check("after_abort_last", 32'(last_data_seen), 32'd16);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
